// File: rtl/pipe_stage_chain.sv
// Parametrised valid/ready stage-register chain with per-stage stall/flush; optional perf counters under PIPE_CHAIN_PERF_EN.
// Latency DEPTH cycles, one item/cycle; COLLAPSE=1 lets bubbles fill behind a blocked stage, COLLAPSE=0 freezes in lockstep.
module pipe_stage_chain #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int COLLAPSE = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic [DEPTH-1:0] stall,
  input  logic [DEPTH-1:0] flush,
  output logic [3:0]       occupancy,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_out
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] ev;
  logic [DEPTH-1:0] off;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] v_nxt;
  logic [3:0]       occ_nxt;
  logic [WIDTH-1:0] d   [DEPTH];
  logic [WIDTH-1:0] src [DEPTH];

  assign ev        = v & ~flush;
  assign out_valid = ev[DEPTH-1] & ~stall[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign in_ready  = rdy[0];

  // Ready ripples from the exit back to the entry, one level per stage.
  always_comb begin
    logic acc;
    rdy = '0;
    acc = (COLLAPSE != 0) ? out_ready : (out_ready | ~ev[DEPTH-1]);
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (COLLAPSE != 0) acc = ~stall[i] & (~ev[i] | acc);
      else               acc = acc & ~stall[i];
      rdy[i] = acc;
    end
  end

  always_comb begin
    off    = '0;
    off[0] = in_valid;
    src[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      off[i] = ev[i-1] & ~stall[i-1];
      src[i] = d[i-1];
    end
  end

  always_comb begin
    v_nxt   = '0;
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_nxt[i] = rdy[i] ? off[i] : ev[i];
      occ_nxt  = occ_nxt + {3'b000, v_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      v         <= v_nxt;
      occupancy <= occ_nxt;
      // Payload only moves with a real offer, so idle stages never toggle.
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i] && off[i]) d[i] <= src[i];
      end
    end
  end

`ifdef PIPE_CHAIN_PERF_EN
  logic [CNT_W-1:0] kill_cnt;

  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_cnt = kill_cnt + {{(CNT_W-1){1'b0}}, v[i] & flush[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
      perf_out   <= '0;
    end else begin
      perf_stall <= perf_stall + {{(CNT_W-1){1'b0}}, in_valid & ~in_ready};
      perf_flush <= perf_flush + kill_cnt;
      perf_out   <= perf_out + {{(CNT_W-1){1'b0}}, out_valid & out_ready};
    end
  end
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
  assign perf_out   = '0;
`endif

endmodule
